// File: rtl/ej32_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ej32_pkg : shared constants and types for the eJ32 memory arbiter
// Rev 1.0
// ------------------------------------------------------------------
package ej32_pkg;

  localparam int IU_ASZ    = 17;
  localparam int REQ_HOST  = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_FETCH = 2;

  typedef logic [IU_ASZ-1:0] iu_addr_t;
  typedef logic [1:0]        req_idx_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ej32_arb_pri.sv
`default_nettype none
// ------------------------------------------------------------------
// ej32_arb_pri : fixed-priority picker (lowest index) with forced winner
// Rev 1.0
// ------------------------------------------------------------------
module ej32_arb_pri
  import ej32_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  req_idx_t        force_idx,
  input  logic            force_en,
  output logic [NREQ-1:0] gnt,
  output req_idx_t        idx,
  output logic            any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    if (force_en) begin
      gnt[force_idx] = req[force_idx];
      idx            = force_idx;
      any            = req[force_idx];
    end else begin
      // Scan downwards so the lowest requesting index is the last to stick.
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          idx    = req_idx_t'(i);
          any    = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ej32_mem_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// ej32_mem_arb : single-port byte-memory arbiter (host / data / fetch)
// Rev 1.0
// ------------------------------------------------------------------
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int ASZ        = IU_ASZ,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ-1:0][ASZ-1:0]  addr,
  input  logic [NREQ-1:0][7:0]      wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rvalid,
  output logic [7:0]                rdata,
  output logic [ASZ-1:0]            mem_addr,
  output logic                      mem_we,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  output logic [1:0]                owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  arb_state_t      r_state, w_state_nx;
  req_idx_t        r_owner, w_owner_nx;
  logic [LW-1:0]   r_lock_cnt, w_lock_cnt_nx;
  logic [SW-1:0]   r_starve, w_starve_nx;
  logic            r_rd_vld;
  req_idx_t        r_rd_owner;
  logic [ASZ-1:0]  r_last_addr;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_gnt;
  req_idx_t        w_idx;
  req_idx_t        w_force_idx;
  logic            w_force_en;
  logic            w_any;
  logic            w_lock_hold;
  logic            w_promote;

  // Nothing can win while reset is asserted.
  assign w_req       = req & {NREQ{rst}};
  assign w_lock_hold = (r_state == ARB_OWNED) && w_req[r_owner] &&
                       (r_lock_cnt < LW'(LOCK_MAX));
  assign w_promote   = (r_starve == SW'(STARVE_MAX)) && w_req[REQ_FETCH];
  assign w_force_en  = w_lock_hold || w_promote;
  assign w_force_idx = w_lock_hold ? r_owner : req_idx_t'(REQ_FETCH);

  ej32_arb_pri #(
    .NREQ (NREQ)
  ) u_pri (
    .req       (w_req),
    .force_idx (w_force_idx),
    .force_en  (w_force_en),
    .gnt       (w_gnt),
    .idx       (w_idx),
    .any       (w_any)
  );

  assign gnt       = w_gnt;
  assign mem_we    = w_any && we[w_idx];
  assign mem_wdata = w_any ? wdata[w_idx] : 8'h00;
  assign mem_addr  = !rst ? '0 : (w_any ? addr[w_idx] : r_last_addr);
  assign rdata     = mem_rdata;
  assign owner     = rst ? r_owner : 2'd0;

  always_comb begin
    rvalid = '0;
    if (rst && r_rd_vld) rvalid[r_rd_owner] = 1'b1;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_owner_nx    = r_owner;
    w_lock_cnt_nx = r_lock_cnt;
    w_starve_nx   = r_starve;
    if (w_any) begin
      w_owner_nx = w_idx;
      if (lock[w_idx]) begin
        // Only a held lock continues the count; a fresh or re-won burst restarts.
        w_state_nx    = ARB_OWNED;
        w_lock_cnt_nx = w_lock_hold ? r_lock_cnt + 1'b1 : LW'(1);
      end else begin
        w_state_nx    = ARB_IDLE;
        w_lock_cnt_nx = '0;
      end
    end else if ((r_state == ARB_OWNED) && !w_req[r_owner]) begin
      w_state_nx    = ARB_IDLE;
      w_lock_cnt_nx = '0;
    end
    if (!w_req[REQ_FETCH] || w_gnt[REQ_FETCH]) begin
      w_starve_nx = '0;
    end else if (r_starve != SW'(STARVE_MAX)) begin
      w_starve_nx = r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= '0;
      r_lock_cnt  <= '0;
      r_starve    <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_owner  <= '0;
      r_last_addr <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_lock_cnt <= w_lock_cnt_nx;
      r_starve   <= w_starve_nx;
      r_rd_vld   <= w_any && !we[w_idx];
      r_rd_owner <= w_idx;
      if (w_any) r_last_addr <= addr[w_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ej32_mem_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ej32_mem_arb : scoreboard bench for the eJ32 memory arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_ej32_mem_arb;
  import ej32_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [2:0]         req = '0, we = '0, lock = '0;
  iu_addr_t [2:0]     addr = '0;
  logic [2:0][7:0]    wdata = '0;
  logic [2:0]         gnt, rvalid;
  logic [7:0]         rdata, mem_wdata;
  logic [7:0]         mem_rdata = 8'h00;
  iu_addr_t           mem_addr;
  logic               mem_we;
  logic [1:0]         owner;

  int tests_run = 0;
  int fails     = 0;
  int cyc       = 0;

  logic [7:0] mem [0:(1<<IU_ASZ)-1];
  logic [7:0] ref_mem [int];

  typedef struct {
    int         due;
    logic [2:0] oh;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  ej32_mem_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [7:0] pat(input iu_addr_t a);
    return a[7:0] ^ a[15:8] ^ {7'd0, a[16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input iu_addr_t a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pat(a);
  endfunction

  task automatic push_rd(input int i, input iu_addr_t a);
    sb.push_back('{due: cyc + 1, oh: 3'(1 << i), data: ref_rd(a)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-return scoreboard: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      tests_run++;
      if (rvalid !== e.oh || rdata !== e.data) begin
        fails++;
        $display("FAIL rd_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                 cyc, rvalid, rdata, e.oh, e.data);
      end
    end else if (rvalid !== 3'b000) begin
      tests_run++;
      fails++;
      $display("FAIL spurious_rvalid cyc=%0d got rvalid=%b want 000", cyc, rvalid);
    end
  end

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0; req = 3'b111; we = 3'b000; lock = 3'b111;
    addr[0] = 17'h00010; addr[1] = 17'h00020; addr[2] = 17'h00030;
    wdata[0] = 8'h11;
    tick(); tick();
    tests_run++; if (gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt got %b want 000", gnt); end
    tests_run++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    tests_run++; if (rvalid !== 3'b000) begin fails++; $display("FAIL reset_rvalid got %b want 000", rvalid); end
    tests_run++; if (mem_addr !== 17'h0 || mem_wdata !== 8'h00 || owner !== 2'd0) begin
      fails++; $display("FAIL reset_outs got addr=%h wdata=%h owner=%0d want 0/0/0", mem_addr, mem_wdata, owner);
    end
    rst = 1'b1; lock = 3'b000; #1;
    tests_run++; if (gnt !== 3'b001) begin fails++; $display("FAIL release_gnt got %b want 001", gnt); end
    push_rd(0, addr[0]);
    tick();
  endtask

  task automatic test_priority();
    req = 3'b110; we = 3'b000; lock = 3'b000;
    addr[1] = 17'h00100; addr[2] = 17'h00200; #1;
    tests_run++; if (gnt !== 3'b010) begin fails++; $display("FAIL prio_gnt got %b want 010", gnt); end
    tests_run++; if (mem_addr !== 17'h00100 || mem_we !== 1'b0) begin
      fails++; $display("FAIL prio_mux got addr=%h we=%b want 00100/0", mem_addr, mem_we);
    end
    push_rd(1, 17'h00100);
    tick();
    req = 3'b000; #1;
    tests_run++; if (rvalid !== 3'b010 || rdata !== ref_rd(17'h00100)) begin
      fails++; $display("FAIL prio_rd got rvalid=%b rdata=%h want 010/%h", rvalid, rdata, ref_rd(17'h00100));
    end
    tests_run++; if (gnt !== 3'b000 || mem_addr !== 17'h00100 || mem_we !== 1'b0) begin
      fails++; $display("FAIL idle_hold got gnt=%b addr=%h we=%b want 000/00100/0", gnt, mem_addr, mem_we);
    end
    tests_run++; if (owner !== 2'd1) begin fails++; $display("FAIL prio_owner got %0d want 1", owner); end
    tick();
  endtask

  task automatic test_lock_burst();
    logic [2:0] rq [10] = '{3'b100, 3'b110, 3'b110, 3'b110, 3'b110,
                            3'b100, 3'b110, 3'b110, 3'b110, 3'b110};
    int         ex [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    int         prev = 1;
    for (int i = 0; i < 10; i++) begin
      req = rq[i]; lock = 3'b100; we = 3'b000;
      addr[1] = iu_addr_t'(17'h00400 + i);
      addr[2] = iu_addr_t'(17'h00300 + i);
      #1;
      tests_run++; if (gnt !== 3'(1 << ex[i])) begin
        fails++; $display("FAIL lock_beat%0d got gnt=%b want %b", i + 1, gnt, 3'(1 << ex[i]));
      end
      tests_run++; if (owner !== 2'(prev)) begin
        fails++; $display("FAIL lock_owner%0d got %0d want %0d", i + 1, owner, prev);
      end
      push_rd(ex[i], addr[ex[i]]);
      prev = ex[i];
      tick();
    end
    req = 3'b000; lock = 3'b000;
    tick();
  endtask

  task automatic test_starvation();
    int exi;
    for (int i = 0; i < 10; i++) begin
      req = 3'b110; lock = 3'b000; we = 3'b000;
      addr[1] = iu_addr_t'(17'h00500 + i);
      addr[2] = iu_addr_t'(17'h00600 + i);
      exi = (i == 8) ? 2 : 1;
      #1;
      tests_run++; if (gnt !== 3'(1 << exi)) begin
        fails++; $display("FAIL starve_cyc%0d got gnt=%b want %b", i + 1, gnt, 3'(1 << exi));
      end
      push_rd(exi, addr[exi]);
      tick();
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_write();
    req = 3'b001; we = 3'b001; lock = 3'b000;
    addr[0] = 17'h1FFFF; wdata[0] = 8'hA5; #1;
    tests_run++; if (gnt !== 3'b001 || mem_we !== 1'b1) begin
      fails++; $display("FAIL wr_strobe got gnt=%b we=%b want 001/1", gnt, mem_we);
    end
    tests_run++; if (mem_addr !== 17'h1FFFF || mem_wdata !== 8'hA5) begin
      fails++; $display("FAIL wr_bus got addr=%h wdata=%h want 1ffff/a5", mem_addr, mem_wdata);
    end
    ref_mem[int'(17'h1FFFF)] = 8'hA5;
    tick();
    req = 3'b000; we = 3'b000; #1;
    tests_run++; if (rvalid !== 3'b000) begin fails++; $display("FAIL wr_no_rvalid got %b want 000", rvalid); end
    tick();
    req = 3'b100; addr[2] = 17'h1FFFF; #1;
    tests_run++; if (gnt !== 3'b100) begin fails++; $display("FAIL wr_readback_gnt got %b want 100", gnt); end
    push_rd(2, 17'h1FFFF);
    tick();
    req = 3'b000;
    tick();
  endtask

  task automatic test_reset_midburst();
    req = 3'b010; lock = 3'b010; we = 3'b000; addr[1] = 17'h00700; #1;
    tests_run++; if (gnt !== 3'b010) begin fails++; $display("FAIL mb_beat1 got %b want 010", gnt); end
    push_rd(1, 17'h00700);
    tick();
    addr[1] = 17'h00701; #1;
    tests_run++; if (gnt !== 3'b010) begin fails++; $display("FAIL mb_beat2 got %b want 010", gnt); end
    tick();
    rst = 1'b0; #1;
    tests_run++; if (gnt !== 3'b000 || rvalid !== 3'b000 || mem_we !== 1'b0) begin
      fails++; $display("FAIL mb_reset got gnt=%b rvalid=%b we=%b want 000/000/0", gnt, rvalid, mem_we);
    end
    tick();
    rst = 1'b1; req = 3'b011; addr[0] = 17'h00800; #1;
    tests_run++; if (gnt !== 3'b001) begin fails++; $display("FAIL mb_after got gnt=%b want 001", gnt); end
    tests_run++; if (owner !== 2'd0) begin fails++; $display("FAIL mb_owner got %0d want 0", owner); end
    push_rd(0, 17'h00800);
    tick();
    req = 3'b000; lock = 3'b000;
    tick();
  endtask

  initial begin
    for (int i = 0; i < (1 << IU_ASZ); i++) mem[i] = pat(iu_addr_t'(i));
    test_reset();
    test_priority();
    test_lock_burst();
    test_starvation();
    test_write();
    test_reset_midburst();
    repeat (3) tick();
    tests_run++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ej32_mem_arb.md
Name: ej32_mem_arb

Overview:
Single-port byte-memory arbiter for the eJ32 core. Three requesters share the 128K x 8 memory bus: host/debug port, data load/store path, and branching-unit fetch (opcode, branch operand and jsr address fetch).
- Per-cycle grant is combinational.
- Multi-byte operand/jsr reads can lock the bus for a bounded burst.
- Fetch has a starvation guard.
- Read data returns one cycle after the granted beat, routed to the issuing requester.

Parameters:
NREQ, 3, number of requesters (0=host, 1=data, 2=fetch); index order is the fixed priority
ASZ, 17, byte address width
STARVE_MAX, 8, consecutive denied fetch cycles before fetch is promoted to top priority
LOCK_MAX, 4, maximum consecutive locked beats before forced re-arbitration

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
req  in  NREQ  beat request per requester
we  in  NREQ  write enable per requester
lock  in  NREQ  keep bus after this beat (burst)
addr  in  NREQ x ASZ  byte address per requester
wdata  in  NREQ x 8  write byte per requester
gnt  out  NREQ  one-hot beat grant, same cycle as req
rvalid  out  NREQ  read data valid for requester, one cycle after its read beat
rdata  out  8  read byte, broadcast; qualify with rvalid
mem_addr  out  ASZ  memory address
mem_we  out  1  memory write strobe
mem_wdata  out  8  memory write byte
mem_rdata  in  8  memory read byte, valid the cycle after the address is presented
owner  out  2  index of last granted requester (debug)

Behaviour:
- At most one beat per cycle. gnt is one-hot or zero. gnt[i] only if req[i].
- While rst=0: gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=0. All registers are cleared: lock_cnt=0, starve_cnt=0, locked=0, rd_owner invalid.
- Reset mid-burst drops the lock. A read issued in the cycle reset is applied produces no rvalid.
- Winner selection, evaluated in order:
  1. Locked owner: locked=1, req[owner]=1 and lock_cnt<LOCK_MAX -> owner.
  2. Starvation: starve_cnt==STARVE_MAX and req[2] -> 2.
  3. Otherwise the lowest index with req set.
- Memory mux: mem_addr, mem_we and mem_wdata come from the winner. With no winner, mem_addr holds the previous value and mem_we=0.
- State (IDLE/OWNED, encoded by the `locked` bit), updated on a granted beat:
  - lock[w]=1 -> OWNED with owner=w; lock_cnt increments (reset to 1 on a new owner).
  - lock[w]=0 -> IDLE, lock_cnt=0.
  - OWNED with req[owner]=0 -> IDLE, lock_cnt=0. The bus is not reserved for an idle owner.
  - lock_cnt==LOCK_MAX -> the lock is ignored for one arbitration. Normal priority applies, and the owner may still win. If it does, lock_cnt restarts at 1.
- Starve counter:
  - Increments when req[2]=1 and gnt[2]=0; saturates at STARVE_MAX.
  - Clears on gnt[2]=1 or req[2]=0.
  - Promotion does not break a locked burst that is under LOCK_MAX.
- Read return: rd_owner is registered as w when gnt[w]=1 and we[w]=0. Next cycle rvalid[rd_owner]=1 and rdata=mem_rdata.
- Back-to-back reads give rvalid every cycle. Writes produce no rvalid.
- Write with simultaneous read: impossible, since there is one beat per cycle.
- owner updates on every granted beat.
- Address arithmetic is the requester's job. The arbiter does no increment or wrap.

Decomposition:
- ej32_pkg gains:
  - requester index constants REQ_HOST=0, REQ_DATA=1, REQ_FETCH=2
  - typedef for the arbiter state (ARB_IDLE, ARB_OWNED)
  - `IU-width address type, reused for addr/mem_addr
- One sub-module, ej32_arb_pri: combinational priority picker (req vector, forced index, force enable -> one-hot grant plus index).
- Counters, lock state and read-return pipeline stay in ej32_mem_arb.

Test Plan:
- Reset: hold rst=0 with req=3'b111 -> gnt=0, mem_we=0, rvalid=0. Release -> same cycle gnt=3'b001.
- Priority: req=3'b110, we=0, addr1=0x00100, addr2=0x00200 -> gnt=3'b010, mem_addr=0x00100. Next cycle rvalid=3'b010 and rdata equals memory[0x00100].
- Lock burst: fetch req+lock for 6 cycles while data req is held -> fetch granted beats 1-4. Beat 5: data wins (gnt=3'b010). Beat 6: fetch is regranted with lock_cnt=1.
- Starvation: data req held continuously, fetch req held -> fetch denied 8 cycles. Cycle 9: gnt=3'b100 with starve_cnt cleared. Cycle 10: data wins again.
- Write/no rvalid: host we=1, addr=0x1FFFF, wdata=0xA5 -> mem_we=1, mem_addr=0x1FFFF, mem_wdata=0xA5. Next cycle rvalid=0. A later fetch read of 0x1FFFF returns 0xA5.
- Reset mid-burst: data lock after 2 beats, rst=0 for one cycle -> locked=0, lock_cnt=0, no rvalid. After reset, host req wins over data.
